// File: rtl/interval_timer_arb.sv
// Shared interval timer: two requesters take turns (round-robin) on one M-bit
// up-counter that runs len+1 qualified ce ticks and then pulses done.
module interval_timer_arb #(
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         R,
    input  logic         ce,
    input  logic         req0,
    input  logic         req1,
    input  logic [M-1:0] len0,
    input  logic [M-1:0] len1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic         busy,
    output logic [M-1:0] Q,
    output logic         TC,
    output logic         CEO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } StateT;

    StateT        state;
    StateT        nextState;
    logic [M-1:0] lenL;
    logic [M-1:0] nextLenL;
    logic [M-1:0] nextQ;
    logic         owner;
    logic         nextOwner;
    logic         last;
    logic         nextLast;
    logic         winner;
    logic         ownerReq;

    // On a tie the requester that was not served last wins; last resets to 1 so req0 wins first.
    assign winner   = (req0 & req1) ? ~last : req1;
    assign ownerReq = owner ? req1 : req0;

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state <= IDLE;
            Q     <= '0;
            lenL  <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= nextState;
            Q     <= nextQ;
            lenL  <= nextLenL;
            owner <= nextOwner;
            last  <= nextLast;
        end
    end

    // An abort (granted req dropped) outranks completion and counting while in RUN.
    always_comb begin
        nextState = state;
        nextQ     = Q;
        nextLenL  = lenL;
        nextOwner = owner;
        nextLast  = last;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    nextState = RUN;
                    nextOwner = winner;
                    nextLenL  = winner ? len1 : len0;
                    nextQ     = '0;
                end
            end
            RUN: begin
                if (!ownerReq) begin
                    nextState = IDLE;
                    nextQ     = '0;
                    nextLast  = owner;
                end else if (ce && (Q == lenL)) begin
                    nextState = DONE;
                end else if (ce) begin
                    nextQ = Q + 1'b1;
                end
            end
            DONE: begin
                nextState = IDLE;
                nextQ     = '0;
                nextLast  = owner;
            end
            default: begin
                nextState = IDLE;
                nextQ     = '0;
            end
        endcase
    end

    always_comb begin
        busy  = (state == RUN) || (state == DONE);
        gnt0  = busy & ~owner;
        gnt1  = busy & owner;
        done0 = (state == DONE) & ~owner;
        done1 = (state == DONE) & owner;
        TC    = (state == RUN) && (Q == lenL);
        CEO   = ce & TC;
    end

endmodule
